pal_seq_array: RTL



---
 rtl/pal_pkg.sv | 44 ++++
 rtl/pal_seq_array_if.sv | 34 +++
 rtl/pal_macrocell.sv | 44 ++++
 rtl/pal_seq_array.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pal_pkg
//  Description : Shared types and bitstream-geometry helpers for the
//                sequential PAL array (state encoding, configuration
//                stream offsets, load counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package pal_pkg;

  // Configuration/run state of the array
  typedef enum logic [1:0] {
    ST_UNCFG = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Number of AND-plane literal sources: external inputs plus register feedback
  function automatic int pal_nin(input int ni, input int no);
    return ni + no;
  endfunction

  // First OR-plane bit: follows the true/complement pair of every literal per term
  function automatic int pal_or_base(input int ni, input int nt, input int no);
    return 2 * pal_nin(ni, no) * nt;
  endfunction

  // First macrocell bit: follows one OR connection per (output, term)
  function automatic int pal_mc_base(input int ni, input int nt, input int no);
    return pal_or_base(ni, nt, no) + nt * no;
  endfunction

  // Total configuration stream length: mode and invert bit per macrocell at the end
  function automatic int pal_len(input int ni, input int nt, input int no);
    return pal_mc_base(ni, nt, no) + 2 * no;
  endfunction

  // Load counter must be able to hold the value LEN itself
  function automatic int pal_cnt_w(input int ni, input int nt, input int no);
    return $clog2(pal_len(ni, nt, no) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pal_seq_array_if.sv
`default_nettype none
// ============================================================================
//  Module      : pal_seq_array_if
//  Description : Configuration stream, data and enable bundle between the
//                TinyTapeout wrapper (master) and the PAL array (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pal_seq_array_if #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_OUTPUTS = 5
);
  import pal_pkg::*;

  logic                   cfg_start;
  logic                   cfg_valid;
  logic                   cfg_bit;
  logic                   cfg_done;
  logic                   cfg_dout;
  logic                   enable;
  logic [NUM_INPUTS-1:0]  in_data;
  logic [NUM_OUTPUTS-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, enable, in_data,
    input  cfg_done, cfg_dout, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, enable, in_data,
    output cfg_done, cfg_dout, out_data
  );

endinterface
`default_nettype wire

// File: rtl/pal_macrocell.sv
`default_nettype none
// ============================================================================
//  Module      : pal_macrocell
//  Description : One output macrocell: optional inversion of the OR sum, a
//                D register with clock enable and synchronous clear, and the
//                combinational/registered output select.
//  Revision    : 1.0 - initial release
// ============================================================================
module pal_macrocell
  import pal_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic or_i,
  input  logic reg_mode_i,
  input  logic invert_i,
  input  logic clr_i,
  input  logic ce_i,
  output logic q_o,
  output logic out_o
);

  logic value_d;
  logic q_q;

  assign value_d = or_i ^ invert_i;

  // Macrocell register: clear wins over a load so a restart always starts from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (clr_i) begin
      q_q <= 1'b0;
    end else if (ce_i) begin
      q_q <= value_d;
    end
  end

  // Feedback is always taken from the register, never from the comb path
  assign q_o   = q_q;
  assign out_o = reg_mode_i ? q_q : value_d;

endmodule
`default_nettype wire

// File: rtl/pal_seq_array.sv
`default_nettype none
// ============================================================================
//  Module      : pal_seq_array
//  Description : Serially configured sequential PAL. AND plane over data
//                inputs and macrocell register feedback, OR plane, and one
//                pal_macrocell per output. Configuration is shifted in so
//                that the k-th accepted bit ends at cfg[k].
//  Options     : PAL_READBACK_EN - when defined, cfg_dout returns the old
//                configuration, one bit per accepted bit, during a reload.
//  Revision    : 1.0 - initial release
// ============================================================================
module pal_seq_array
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_TERMS   = 11,
  parameter int NUM_OUTPUTS = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  pal_seq_array_if.slave  bus
);

  localparam int c_nin     = pal_nin(NUM_INPUTS, NUM_OUTPUTS);
  localparam int c_or_base = pal_or_base(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int c_mc_base = pal_mc_base(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int c_len     = pal_len(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int c_cnt_w   = pal_cnt_w(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);

  state_e                 state_q;
  logic [c_cnt_w-1:0]     cnt_q;
  logic                   done_q;
  logic [c_len-1:0]       cfg_q;
  logic [c_len-1:0]       cfg_d;

  logic                   w_accept;
  logic                   w_run;
  logic [c_nin-1:0]       w_lit;
  logic [NUM_TERMS-1:0]   w_term;
  logic [NUM_OUTPUTS-1:0] w_q;
  logic [NUM_OUTPUTS-1:0] w_mc_out;

  // A restart takes priority, so a bit presented with cfg_start is dropped
  assign w_accept = (state_q == ST_LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign w_run    = (state_q == ST_READY) && bus.enable;

  // Control FSM with registered cfg_done; the counter stops at LEN by leaving LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNCFG;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (bus.cfg_start) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.cfg_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == c_cnt_w'(c_len - 1)) begin
              state_q <= ST_READY;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // New bits enter at the top so the first accepted bit finishes at cfg[0]
  assign cfg_d = w_accept ? {bus.cfg_bit, cfg_q[c_len-1:1]} : cfg_q;

  // Configuration store; a restart keeps the old image so it can be read back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

`ifdef PAL_READBACK_EN
  logic dout_q;

  // Capture the bit falling off cfg[0] on every accepted shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else if (w_accept) begin
      dout_q <= cfg_q[0];
    end
  end

  assign bus.cfg_dout = dout_q;
`else
  assign bus.cfg_dout = 1'b0;
`endif

  // Literal sources: data inputs low, macrocell registers high
  assign w_lit = {w_q, bus.in_data};

  for (genvar p = 0; p < NUM_TERMS; p++) begin : g_term
    logic [c_nin-1:0] w_true_sel;
    logic [c_nin-1:0] w_comp_sel;

    for (genvar j = 0; j < c_nin; j++) begin : g_lit
      assign w_true_sel[j] = cfg_q[2*c_nin*p + 2*j];
      assign w_comp_sel[j] = cfg_q[2*c_nin*p + 2*j + 1];
    end

    // An unprogrammed term must read 0, not the vacuous AND of nothing
    assign w_term[p] = (|(w_true_sel | w_comp_sel)) &
                       (&((~w_true_sel | w_lit) & (~w_comp_sel | ~w_lit)));
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    logic [NUM_TERMS-1:0] w_or_mask;
    logic                 w_or;

    assign w_or_mask = cfg_q[c_or_base + o*NUM_TERMS +: NUM_TERMS];
    assign w_or      = |(w_term & w_or_mask);

    pal_macrocell u_mc (
      .clk        (clk),
      .rst_n      (rst_n),
      .or_i       (w_or),
      .reg_mode_i (cfg_q[c_mc_base + 2*o]),
      .invert_i   (cfg_q[c_mc_base + 2*o + 1]),
      .clr_i      (bus.cfg_start),
      .ce_i       (w_run),
      .q_o        (w_q[o]),
      .out_o      (w_mc_out[o])
    );
  end

  assign bus.out_data = w_run ? w_mc_out : '0;
  assign bus.cfg_done = done_q;

endmodule
`default_nettype wire
